// File: rtl/dff_prst_rst_sequencer.sv
// dff_prst_rst_sequencer: turns one-cycle set/clear requests into registered,
// mutually exclusive preset/clear pulses of PULSE_W cycles, each followed by
// GAP_W guard cycles and a one-cycle done. One pending request of each kind
// is queued while busy; preset wins over clear.
// Optional build macro SEQ_POWER_ON_CLEAR_EN: issue one automatic clear pulse
// on the first cycle after reset is released.
module dff_prst_rst_sequencer #(
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   output logic ff_prst,
   output logic ff_rst,
   output logic busy,
   output logic done
);

   localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int CW   = (MAXW < 1) ? 1 : $clog2(MAXW + 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'((GAP_W > 0) ? GAP_W - 1 : 0);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRST_ACT = 2'd1,
      RST_ACT  = 2'd2,
      GUARD    = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pend_set, pend_set_nxt;
   logic          pend_clr, pend_clr_nxt;
   logic          done_nxt;
   logic          decide;
   logic          eff_set, eff_clr;
`ifdef SEQ_POWER_ON_CLEAR_EN
   logic          por, por_nxt;
`endif

   assign eff_set = pend_set | set_req;
   assign eff_clr = pend_clr | clr_req;
   assign busy    = (state != IDLE);

   // Next-state, counter, pending-request and done computation.
   // A request seen on the decision edge is served directly rather than
   // pended first, so no cycle is lost between back-to-back pulses.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pend_set_nxt = pend_set | set_req;
      pend_clr_nxt = pend_clr | clr_req;
      done_nxt     = 1'b0;
      decide       = 1'b0;
`ifdef SEQ_POWER_ON_CLEAR_EN
      por_nxt      = por;
`endif
      case (state)
         IDLE: begin
`ifdef SEQ_POWER_ON_CLEAR_EN
            if (por) begin
               state_nxt = RST_ACT;
               cnt_nxt   = PULSE_LD;
               por_nxt   = 1'b0;
            end else begin
               decide = 1'b1;
            end
`else
            decide = 1'b1;
`endif
         end
         PRST_ACT, RST_ACT: begin
            if (cnt == '0) begin
               if (GAP_W == 0) begin
                  done_nxt = 1'b1;
                  decide   = 1'b1;
               end else begin
                  state_nxt = GUARD;
                  cnt_nxt   = GAP_LD;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         GUARD: begin
            if (cnt == '0) begin
               done_nxt = 1'b1;
               decide   = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (decide) begin
         if (eff_set) begin
            state_nxt    = PRST_ACT;
            cnt_nxt      = PULSE_LD;
            pend_set_nxt = 1'b0;
            pend_clr_nxt = eff_clr;
         end else if (eff_clr) begin
            state_nxt    = RST_ACT;
            cnt_nxt      = PULSE_LD;
            pend_set_nxt = 1'b0;
            pend_clr_nxt = 1'b0;
         end else begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            pend_set_nxt = 1'b0;
            pend_clr_nxt = 1'b0;
         end
      end
   end

   // State register with registered pulse outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pend_set <= 1'b0;
         pend_clr <= 1'b0;
         ff_prst  <= 1'b0;
         ff_rst   <= 1'b0;
         done     <= 1'b0;
`ifdef SEQ_POWER_ON_CLEAR_EN
         por      <= 1'b1;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pend_set <= pend_set_nxt;
         pend_clr <= pend_clr_nxt;
         ff_prst  <= (state_nxt == PRST_ACT);
         ff_rst   <= (state_nxt == RST_ACT);
         done     <= done_nxt;
`ifdef SEQ_POWER_ON_CLEAR_EN
         por      <= por_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_dff_prst_rst_sequencer.sv
// Bench for dff_prst_rst_sequencer: two instances (PULSE_W=2/GAP_W=1 and
// PULSE_W=1/GAP_W=0) share directed then random stimulus; expected outputs
// come from a timeline model that schedules whole pulses into arrays.
module tb_dff_prst_rst_sequencer;

   localparam int N = 1200;

   logic       clk = 1'b0;
   logic       rst, set_req, clr_req;
   logic [1:0] prst, rsto, busy, done;

   int vectors     = 0;
   int miscompares = 0;
   int e           = 0;

   bit ex_p [2][N];
   bit ex_r [2][N];
   bit ex_b [2][N];
   bit ex_d [2][N];
   int free_at [2];
   bit pset [2];
   bit pclr [2];
   bit por  [2];

   dff_prst_rst_sequencer #(.PULSE_W(2), .GAP_W(1)) u0 (
      .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
      .ff_prst(prst[0]), .ff_rst(rsto[0]), .busy(busy[0]), .done(done[0])
   );

   dff_prst_rst_sequencer #(.PULSE_W(1), .GAP_W(0)) u1 (
      .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
      .ff_prst(prst[1]), .ff_rst(rsto[1]), .busy(busy[1]), .done(done[1])
   );

   always #5 clk = ~clk;

   function automatic int pw(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic int gw(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   // Lay a whole pulse + guard + done into the expected timeline from edge s.
   task automatic schedule(input int i, input int s, input bit is_set);
      int p = pw(i);
      int g = gw(i);
      for (int k = s; k < s + p; k++) begin
         if (is_set) ex_p[i][k] = 1'b1;
         else        ex_r[i][k] = 1'b1;
      end
      for (int k = s; k < s + p + g; k++) ex_b[i][k] = 1'b1;
      ex_d[i][s + p + g] = 1'b1;
      free_at[i] = s + p + g;
   endtask

   task automatic model(input int i, input int edg, input bit r, input bit s, input bit c);
      bit es, ec;
      if (r) begin
         for (int k = edg; k < edg + 4; k++) begin
            ex_p[i][k] = 1'b0; ex_r[i][k] = 1'b0;
            ex_b[i][k] = 1'b0; ex_d[i][k] = 1'b0;
         end
         pset[i] = 1'b0; pclr[i] = 1'b0;
         free_at[i] = edg;
         por[i] = 1'b1;
      end else if (edg < free_at[i]) begin
         pset[i] = pset[i] | s;
         pclr[i] = pclr[i] | c;
      end else begin
`ifdef SEQ_POWER_ON_CLEAR_EN
         if (por[i]) begin
            por[i]  = 1'b0;
            pset[i] = pset[i] | s;
            pclr[i] = pclr[i] | c;
            schedule(i, edg, 1'b0);
         end else
`endif
         begin
            por[i] = 1'b0;
            es = pset[i] | s;
            ec = pclr[i] | c;
            pset[i] = 1'b0;
            pclr[i] = 1'b0;
            if (es) begin
               schedule(i, edg, 1'b1);
               pclr[i] = ec;
            end else if (ec) begin
               schedule(i, edg, 1'b0);
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit s, input bit c);
      @(negedge clk);
      rst = r; set_req = s; clr_req = c;
      @(posedge clk);
      model(0, e, r, s, c);
      model(1, e, r, s, c);
      #1;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         assert (prst[i] === ex_p[i][e]) else begin
            miscompares++;
            $error("FAIL ff_prst u%0d edge %0d: got %b expected %b", i, e, prst[i], ex_p[i][e]);
         end
         vectors++;
         assert (rsto[i] === ex_r[i][e]) else begin
            miscompares++;
            $error("FAIL ff_rst u%0d edge %0d: got %b expected %b", i, e, rsto[i], ex_r[i][e]);
         end
         vectors++;
         assert (busy[i] === ex_b[i][e]) else begin
            miscompares++;
            $error("FAIL busy u%0d edge %0d: got %b expected %b", i, e, busy[i], ex_b[i][e]);
         end
         vectors++;
         assert (done[i] === ex_d[i][e]) else begin
            miscompares++;
            $error("FAIL done u%0d edge %0d: got %b expected %b", i, e, done[i], ex_d[i][e]);
         end
         vectors++;
         assert (!(prst[i] && rsto[i])) else begin
            miscompares++;
            $error("FAIL excl u%0d edge %0d: got prst=%b rst=%b expected not both", i, e, prst[i], rsto[i]);
         end
      end
      e++;
   endtask

   initial begin
      rst = 1'b1; set_req = 1'b0; clr_req = 1'b0;
      // reset, then single preset
      repeat (3) step(1, 0, 0);
      repeat (2) step(0, 0, 0);
      step(0, 1, 0);
      repeat (8) step(0, 0, 0);
      // simultaneous set and clear from idle
      step(0, 1, 1);
      repeat (12) step(0, 0, 0);
      // repeated clears during a preset pulse
      step(0, 1, 0);
      repeat (2) step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 1);
      repeat (10) step(0, 0, 0);
      // reset in the middle of a clear pulse, then a fresh request
      step(0, 0, 1);
      step(1, 0, 0);
      repeat (3) step(0, 0, 0);
      step(0, 1, 0);
      repeat (8) step(0, 0, 0);
      // requests on the done / last-pulse cycle
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 1, 0);
      repeat (10) step(0, 0, 0);
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 4) == 0));
      end
      repeat (6) step(0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
